// File: rtl/mesi_pkg.sv
// mesi_pkg: shared types and trace op codes for the MESI line controller
// Contents: MESI line states, trace op codes, bus ops, snoop responses, FSM states.
package mesi_pkg;

    typedef enum logic [1:0] {I, S, E, M} mesi_state_t;

    typedef logic [3:0] op_code_t;
    localparam op_code_t OP_RD   = 4'd0;
    localparam op_code_t OP_WR   = 4'd1;
    localparam op_code_t OP_IF   = 4'd2;
    localparam op_code_t OP_SINV = 4'd3;
    localparam op_code_t OP_SRD  = 4'd4;
    localparam op_code_t OP_SWR  = 4'd5;
    localparam op_code_t OP_SRFO = 4'd6;
    localparam op_code_t OP_CLR  = 4'd8;

    typedef enum logic [1:0] {READ, WRITE, INVALIDATE, RWIM} bus_op_t;

    typedef enum logic [1:0] {NOHIT, HIT, HITM} snoop_rsp_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WB, ST_FILL, ST_RESP} fsm_state_t;

endpackage

// File: rtl/mesi_next_state.sv
// mesi_next_state: combinational MESI transition for one line and one trace op
// Ports:
//   cur_state_i    current MESI state of the addressed line
//   op_code_i      trace op code
//   op_hit_i       tag match from the tag array
//   snoop_rsp_i    other caches' response to our READ (decides S vs E on fill)
//   next_state_o   state to write back when the op retires
//   needs_wb_o     a WRITE of the current M line is required first
//   needs_fill_o   a READ / INVALIDATE / RWIM transaction is required
//   fill_op_o      which fill transaction to issue
//   snoop_result_o our response to a snoop op
module mesi_next_state
    import mesi_pkg::*;
(
    input  mesi_state_t cur_state_i,
    input  logic [3:0]  op_code_i,
    input  logic        op_hit_i,
    input  logic [1:0]  snoop_rsp_i,
    output mesi_state_t next_state_o,
    output logic        needs_wb_o,
    output logic        needs_fill_o,
    output bus_op_t     fill_op_o,
    output snoop_rsp_t  snoop_result_o
);
    logic vld;
    logic is_m;

    // a line only counts as present when the tag matches and it holds data
    assign vld  = op_hit_i && cur_state_i != I;
    assign is_m = cur_state_i == M;

    always_comb begin
        next_state_o   = cur_state_i;
        needs_wb_o     = 1'b0;
        needs_fill_o   = 1'b0;
        fill_op_o      = READ;
        snoop_result_o = NOHIT;
        case (op_code_i)
            OP_RD, OP_IF: if (!vld) begin
                needs_fill_o = 1'b1;
                needs_wb_o   = is_m;
                next_state_o = (snoop_rsp_i == HIT || snoop_rsp_i == HITM) ? S : E;
            end
            OP_WR: begin
                next_state_o = M;
                if (!vld || cur_state_i == S) begin
                    needs_fill_o = 1'b1;
                    needs_wb_o   = !vld && is_m;
                    fill_op_o    = vld ? INVALIDATE : RWIM;
                end
            end
            OP_SRD, OP_SRFO: if (vld) begin
                next_state_o   = op_code_i == OP_SRD ? S : I;
                needs_wb_o     = is_m;
                snoop_result_o = is_m ? HITM : HIT;
            end
            OP_SINV: if (vld && cur_state_i == S) begin
                next_state_o   = I;
                snoop_result_o = HIT;
            end
            OP_CLR: next_state_o = I;
            default: ;
        endcase
    end

endmodule

// File: rtl/mesi_line_ctrl.sv
// mesi_line_ctrl: MESI coherence controller for an N-line cache slice
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   op_valid/op_ready     trace op handshake (ready only in IDLE)
//   op_code/op_index/op_hit  trace op, addressed line, tag match
//   bus_req/bus_op/bus_ack   bus transaction handshake
//   snoop_rsp_in          other caches' response sampled on the READ ack
//   snoop_valid/snoop_result our snoop response, pulsed with done
//   done/line_state       retirement pulse and post-op state of the line
// Optional feature (macro MESI_STATS_EN): hit_cnt, miss_cnt, wb_cnt saturating
// counters of CPU hits, CPU misses and WRITE transactions at retirement.
module mesi_line_ctrl
    import mesi_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [IDX_W-1:0] op_index,
    input  logic             op_hit,
    output logic             bus_req,
    output logic [1:0]       bus_op,
    input  logic             bus_ack,
    input  logic [1:0]       snoop_rsp_in,
    output logic             snoop_valid,
    output logic [1:0]       snoop_result,
    output logic             done,
    output logic [1:0]       line_state
`ifdef MESI_STATS_EN
    ,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wb_cnt
`endif
);
    fsm_state_t       fsm_q;
    mesi_state_t      arr_q [NUM_LINES];
    logic [3:0]       code_q;
    logic [IDX_W-1:0] idx_q;
    logic             hit_q;
    logic             bus_req_q;
    bus_op_t          bus_op_q;
    logic             done_q;
    logic             snoop_valid_q;
    snoop_rsp_t       snoop_result_q;
    mesi_state_t      line_state_q;

    logic             idle;
    logic             ack;
    logic             hit;
    logic             need_wb;
    logic             need_fill;
    logic             snoop_op;
    logic             clr;
    logic             retire;
    logic [3:0]       code;
    logic [IDX_W-1:0] idx;
    mesi_state_t      cur;
    mesi_state_t      nxt;
    bus_op_t          fill_op;
    snoop_rsp_t       snp;

    // in IDLE decide straight from the inputs so bus_req can rise the cycle
    // after accept; afterwards evaluate the registered op against the array,
    // which stays untouched until the op retires
    assign idle     = fsm_q == ST_IDLE;
    assign code     = idle ? op_code : code_q;
    assign idx      = idle ? op_index : idx_q;
    assign hit      = idle ? op_hit : hit_q;
    assign cur      = arr_q[idx];
    assign ack      = bus_ack & bus_req_q;
    assign snoop_op = code inside {OP_SINV, OP_SRD, OP_SWR, OP_SRFO};
    assign clr      = code == OP_CLR;
    assign retire   = idle ? (op_valid & ~need_wb & ~need_fill)
                           : (ack & ((fsm_q == ST_FILL) | ~need_fill));

    mesi_next_state u_next_state (
        .cur_state_i    (cur),
        .op_code_i      (code),
        .op_hit_i       (hit),
        .snoop_rsp_i    (snoop_rsp_in),
        .next_state_o   (nxt),
        .needs_wb_o     (need_wb),
        .needs_fill_o   (need_fill),
        .fill_op_o      (fill_op),
        .snoop_result_o (snp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q          <= ST_IDLE;
            for (int i = 0; i < NUM_LINES; i++) arr_q[i] <= I;
            code_q         <= '0;
            idx_q          <= '0;
            hit_q          <= 1'b0;
            bus_req_q      <= 1'b0;
            bus_op_q       <= READ;
            done_q         <= 1'b0;
            snoop_valid_q  <= 1'b0;
            snoop_result_q <= NOHIT;
            line_state_q   <= I;
        end else begin
            done_q        <= retire;
            snoop_valid_q <= retire & snoop_op;
            case (fsm_q)
                ST_IDLE: if (op_valid) begin
                    code_q    <= op_code;
                    idx_q     <= op_index;
                    hit_q     <= op_hit;
                    fsm_q     <= need_wb ? ST_WB : need_fill ? ST_FILL : ST_RESP;
                    bus_req_q <= need_wb | need_fill;
                    bus_op_q  <= need_wb ? WRITE : fill_op;
                end
                ST_WB: if (ack) begin
                    bus_req_q <= 1'b0;
                    fsm_q     <= need_fill ? ST_FILL : ST_RESP;
                end
                // after a writeback bus_req is low here; raise it for the fill
                ST_FILL: if (ack) begin
                    bus_req_q <= 1'b0;
                    fsm_q     <= ST_RESP;
                end else if (!bus_req_q) begin
                    bus_req_q <= 1'b1;
                    bus_op_q  <= fill_op;
                end
                ST_RESP: fsm_q <= ST_IDLE;
            endcase
            if (retire) begin
                line_state_q   <= nxt;
                snoop_result_q <= snoop_op ? snp : NOHIT;
                if (clr) for (int i = 0; i < NUM_LINES; i++) arr_q[i] <= I;
                else arr_q[idx] <= nxt;
            end
        end
    end

    assign op_ready     = idle;
    assign bus_req      = bus_req_q;
    assign bus_op       = bus_op_q;
    assign done         = done_q;
    assign snoop_valid  = snoop_valid_q;
    assign snoop_result = snoop_result_q;
    assign line_state   = line_state_q;

`ifdef MESI_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;
    logic [CNT_W-1:0] wb_cnt_q;
    logic             cpu;
    logic             vld;

    assign cpu = code inside {OP_RD, OP_WR, OP_IF};
    assign vld = hit & (cur != I);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else if (retire) begin
            hit_cnt_q  <= hit_cnt_q + CNT_W'(cpu & vld & (~&hit_cnt_q));
            miss_cnt_q <= miss_cnt_q + CNT_W'(cpu & ~vld & (~&miss_cnt_q));
            wb_cnt_q   <= wb_cnt_q + CNT_W'(need_wb & (~&wb_cnt_q));
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_mesi_line_ctrl.sv
// tb_mesi_line_ctrl: scoreboard bench for the MESI line controller
module tb_mesi_line_ctrl;
    localparam logic [1:0] LI = 2'd0, LS = 2'd1, LE = 2'd2, LM = 2'd3;
    localparam logic [1:0] B_RD = 2'd0, B_WB = 2'd1, B_INV = 2'd2, B_RWIM = 2'd3;
    localparam logic [1:0] NH = 2'd0, HT = 2'd1, HM = 2'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] op_code = 4'd0;
    logic [3:0] op_index = 4'd0;
    logic       op_hit = 1'b0;
    logic       bus_req;
    logic [1:0] bus_op;
    logic       bus_ack = 1'b0;
    logic [1:0] snoop_rsp_in = 2'd0;
    logic       snoop_valid;
    logic [1:0] snoop_result;
    logic       done;
    logic [1:0] line_state;
`ifdef MESI_STATS_EN
    logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    mesi_line_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_code      (op_code),
        .op_index     (op_index),
        .op_hit       (op_hit),
        .bus_req      (bus_req),
        .bus_op       (bus_op),
        .bus_ack      (bus_ack),
        .snoop_rsp_in (snoop_rsp_in),
        .snoop_valid  (snoop_valid),
        .snoop_result (snoop_result),
        .done         (done),
        .line_state   (line_state)
`ifdef MESI_STATS_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
        .wb_cnt       (wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  c;
        logic [3:0]  x;
        logic        h;
        logic [1:0]  r;
        logic [13:0] e;
    } row_t;

    int          total = 0;
    int          bad = 0;
    int          wait_n;
    logic [13:0] exp_q[$];
    logic [13:0] obs;
    logic [1:0]  bus_seen[$];

    // expected retirement: done seen, line state, snoop flags, bus ops in order,
    // done one cycle after the last ack (or accept), op_ready low after accept
    function automatic logic [13:0] ex(input logic [1:0] ls, input logic sv, input logic [1:0] sr,
                                       input logic [1:0] nb, input logic [1:0] b0, input logic [1:0] b1);
        return {1'b1, ls, sv, sr, nb, b0, b1, 2'b11};
    endfunction

    task automatic send(input logic [3:0] c, input logic [3:0] x, input logic h, input logic [1:0] r);
        int ack_at, lat;
        logic got, rdy_drop, sv;
        logic [1:0] ls, sr, b0, b1;
        @(negedge clk);
        wait_n = 0;
        while (!op_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        op_valid = 1'b1; op_code = c; op_index = x; op_hit = h; snoop_rsp_in = r;
        @(posedge clk);
        #1 op_valid = 1'b0;
        bus_seen.delete();
        got = 1'b0; ack_at = 0; lat = 0; rdy_drop = 1'b0; sv = 1'b0; ls = 2'd0; sr = 2'd0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (k == 1) rdy_drop = !op_ready;
            bus_ack = bus_req;
            if (bus_req) begin
                bus_seen.push_back(bus_op);
                ack_at = k;
            end
            if (done) begin
                got = 1'b1; lat = k; ls = line_state; sv = snoop_valid;
                sr = snoop_valid ? snoop_result : 2'd0;
            end
        end
        bus_ack = 1'b0;
        b0 = bus_seen.size() > 0 ? bus_seen[0] : 2'd0;
        b1 = bus_seen.size() > 1 ? bus_seen[1] : 2'd0;
        obs = {got, ls, sv, sr, 2'(bus_seen.size()), b0, b1, (lat - ack_at) == 1, rdy_drop};
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({op_ready, bus_req, bus_op, done, snoop_valid, snoop_result, line_state} !== 10'b1000000000) begin
            bad++;
            $display("FAIL reset_hold got=%b want=1000000000",
                     {op_ready, bus_req, bus_op, done, snoop_valid, snoop_result, line_state});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({op_ready, bus_req, bus_op, done, snoop_valid, snoop_result, line_state} !== 10'b1000000000) begin
            bad++;
            $display("FAIL reset_release got=%b want=1000000000",
                     {op_ready, bus_req, bus_op, done, snoop_valid, snoop_result, line_state});
        end
    endtask

    task automatic test_cpu_path;
        row_t rows[8];
        logic [13:0] e;
        rows[0] = {4'd0, 4'd3, 1'b0, NH, ex(LE, 1'b0, NH, 2'd1, B_RD, 2'd0)};
        rows[1] = {4'd1, 4'd3, 1'b1, NH, ex(LM, 1'b0, NH, 2'd0, 2'd0, 2'd0)};
        rows[2] = {4'd0, 4'd3, 1'b1, NH, ex(LM, 1'b0, NH, 2'd0, 2'd0, 2'd0)};
        rows[3] = {4'd4, 4'd3, 1'b1, NH, ex(LS, 1'b1, HM, 2'd1, B_WB, 2'd0)};
        rows[4] = {4'd1, 4'd5, 1'b0, NH, ex(LM, 1'b0, NH, 2'd1, B_RWIM, 2'd0)};
        rows[5] = {4'd0, 4'd5, 1'b0, HT, ex(LS, 1'b0, NH, 2'd2, B_WB, B_RD)};
        rows[6] = {4'd2, 4'd7, 1'b0, HM, ex(LS, 1'b0, NH, 2'd1, B_RD, 2'd0)};
        rows[7] = {4'd1, 4'd7, 1'b1, NH, ex(LM, 1'b0, NH, 2'd1, B_INV, 2'd0)};
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].e);
            send(rows[i].c, rows[i].x, rows[i].h, rows[i].r);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL cpu_path[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_snoop;
        row_t rows[10];
        logic [13:0] e;
        rows[0] = {4'd6, 4'd7, 1'b1, NH, ex(LI, 1'b1, HM, 2'd1, B_WB, 2'd0)};
        rows[1] = {4'd6, 4'd7, 1'b1, NH, ex(LI, 1'b1, NH, 2'd0, 2'd0, 2'd0)};
        rows[2] = {4'd3, 4'd3, 1'b1, NH, ex(LI, 1'b1, HT, 2'd0, 2'd0, 2'd0)};
        rows[3] = {4'd0, 4'd4, 1'b0, NH, ex(LE, 1'b0, NH, 2'd1, B_RD, 2'd0)};
        rows[4] = {4'd3, 4'd4, 1'b1, NH, ex(LE, 1'b1, NH, 2'd0, 2'd0, 2'd0)};
        rows[5] = {4'd5, 4'd4, 1'b1, NH, ex(LE, 1'b1, NH, 2'd0, 2'd0, 2'd0)};
        rows[6] = {4'd4, 4'd4, 1'b0, NH, ex(LE, 1'b1, NH, 2'd0, 2'd0, 2'd0)};
        rows[7] = {4'd4, 4'd4, 1'b1, NH, ex(LS, 1'b1, HT, 2'd0, 2'd0, 2'd0)};
        rows[8] = {4'd6, 4'd4, 1'b1, NH, ex(LI, 1'b1, HT, 2'd0, 2'd0, 2'd0)};
        rows[9] = {4'd7, 4'd4, 1'b1, NH, ex(LI, 1'b0, NH, 2'd0, 2'd0, 2'd0)};
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].e);
            send(rows[i].c, rows[i].x, rows[i].h, rows[i].r);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL snoop[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        row_t rows[3];
        logic [13:0] e;
        rows[0] = {4'd1, 4'd9, 1'b0, NH, ex(LM, 1'b0, NH, 2'd1, B_RWIM, 2'd0)};
        rows[1] = {4'd0, 4'd9, 1'b1, NH, ex(LM, 1'b0, NH, 2'd0, 2'd0, 2'd0)};
        rows[2] = {4'd1, 4'd9, 1'b1, NH, ex(LM, 1'b0, NH, 2'd0, 2'd0, 2'd0)};
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].e);
            send(rows[i].c, rows[i].x, rows[i].h, rows[i].r);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL b2b[%0d] got=%h want=%h", i, obs, e);
            end
            if (i > 0) begin
                total++;
                if (wait_n !== 0) begin
                    bad++;
                    $display("FAIL b2b_accept[%0d] got_wait=%0d want_wait=0", i, wait_n);
                end
            end
        end
    endtask

    task automatic test_reset_midtx;
        row_t rows[2];
        logic [13:0] e;
        @(negedge clk);
        op_valid = 1'b1; op_code = 4'd0; op_index = 4'd9; op_hit = 1'b0;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus_req !== 1'b1) begin
            bad++;
            $display("FAIL midtx_req got=%b want=1", bus_req);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({bus_req, op_ready, done} !== 3'b010) begin
            bad++;
            $display("FAIL midtx_reset got=%b want=010", {bus_req, op_ready, done});
        end
        @(negedge clk);
        reset = 1'b1;
        rows[0] = {4'd0, 4'd9, 1'b1, NH, ex(LE, 1'b0, NH, 2'd1, B_RD, 2'd0)};
        rows[1] = {4'd0, 4'd5, 1'b1, NH, ex(LE, 1'b0, NH, 2'd1, B_RD, 2'd0)};
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].e);
            send(rows[i].c, rows[i].x, rows[i].h, rows[i].r);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL after_reset[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_clear;
        row_t rows[3];
        logic [13:0] e;
        rows[0] = {4'd1, 4'd9, 1'b1, NH, ex(LM, 1'b0, NH, 2'd0, 2'd0, 2'd0)};
        rows[1] = {4'd8, 4'd9, 1'b1, NH, ex(LI, 1'b0, NH, 2'd0, 2'd0, 2'd0)};
        rows[2] = {4'd0, 4'd9, 1'b1, HT, ex(LS, 1'b0, NH, 2'd1, B_RD, 2'd0)};
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].e);
            send(rows[i].c, rows[i].x, rows[i].h, rows[i].r);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL clear[%0d] got=%h want=%h", i, obs, e);
            end
        end
    endtask

`ifdef MESI_STATS_EN
    task automatic test_stats;
        row_t rows[6];
        logic [13:0] e;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rows[0] = {4'd0, 4'd1, 1'b0, NH, ex(LE, 1'b0, NH, 2'd1, B_RD, 2'd0)};
        rows[1] = {4'd1, 4'd2, 1'b0, NH, ex(LM, 1'b0, NH, 2'd1, B_RWIM, 2'd0)};
        rows[2] = {4'd0, 4'd1, 1'b1, NH, ex(LE, 1'b0, NH, 2'd0, 2'd0, 2'd0)};
        rows[3] = {4'd1, 4'd1, 1'b1, NH, ex(LM, 1'b0, NH, 2'd0, 2'd0, 2'd0)};
        rows[4] = {4'd2, 4'd2, 1'b1, NH, ex(LM, 1'b0, NH, 2'd0, 2'd0, 2'd0)};
        rows[5] = {4'd4, 4'd2, 1'b1, NH, ex(LS, 1'b1, HM, 2'd1, B_WB, 2'd0)};
        foreach (rows[i]) begin
            exp_q.push_back(rows[i].e);
            send(rows[i].c, rows[i].x, rows[i].h, rows[i].r);
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL stats_op[%0d] got=%h want=%h", i, obs, e);
            end
        end
        @(negedge clk);
        total++;
        if (hit_cnt !== 16'd3) begin
            bad++;
            $display("FAIL hit_cnt got=%0d want=3", hit_cnt);
        end
        total++;
        if (miss_cnt !== 16'd2) begin
            bad++;
            $display("FAIL miss_cnt got=%0d want=2", miss_cnt);
        end
        total++;
        if (wb_cnt !== 16'd1) begin
            bad++;
            $display("FAIL wb_cnt got=%0d want=1", wb_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_path();
        test_snoop();
        test_back_to_back();
        test_reset_midtx();
        test_clear();
`ifdef MESI_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
